// File: rtl/decade_pkg.sv
// decade_pkg: definitions shared by the decade counter controller and its digit cells.
// Contents:
//   ST_IDLE/ST_RUN/ST_HOLD/ST_DONE - controller FSM state encoding
//   BCD_MAX                        - largest legal value of one BCD digit
package decade_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/decade_digit.sv
// decade_digit: one BCD decade (0..9) with synchronous clear, preset and increment.
// Ports:
//   clk  - system clock, rising edge
//   clr  - synchronous active-high clear (highest priority)
//   en   - increment enable for this digit (carry-in)
//   ld   - preset strobe; a value above 9 presets to 0
//   d    - preset value
//   q    - registered digit value, always 0..9
//   co   - carry-out: high when en is high and q is 9
module decade_digit
  import decade_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       co
);

  assign co = en && (q == BCD_MAX);

  // Digit register: clear, then preset, then increment with 9 -> 0 rollover.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= (d > BCD_MAX) ? 4'd0 : d;
    end else if (en) begin
      // >= also recovers from any out-of-range value instead of counting past 9
      q <= (q >= BCD_MAX) ? 4'd0 : q + 4'd1;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/decade_counter_ctrl.sv
// decade_counter_ctrl: DIGITS-digit BCD counter with start/stop/load control,
// programmable terminal count and wrap or one-shot behaviour.
// Ports:
//   clk      - system clock, rising edge
//   clr      - synchronous active-high reset, overrides all commands
//   start    - begin/resume counting (from IDLE, HOLD, or restart from DONE)
//   stop     - pause counting while in RUN
//   load     - preset count from load_val and return to IDLE
//   load_val - BCD preset value, digit 0 in [3:0]
//   tc_val   - BCD terminal count, compared every cycle
//   mode     - 0: wrap to 0 at terminal count, 1: stop in DONE at terminal count
//   count    - registered BCD count
//   running  - high in RUN
//   done     - high in DONE
//   wrap     - one-cycle pulse when count returns to 0 from RUN
// Command priority per cycle: clr > load > stop > start.
module decade_counter_ctrl
  import decade_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                stop,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic [4*DIGITS-1:0] tc_val,
  input  logic                mode,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                done,
  output logic                wrap
);

  localparam int W = 4 * DIGITS;

  logic [1:0]   state;
  logic [1:0]   state_next;
  logic         inc;
  logic         ld_all;
  logic [W-1:0] ld_data;
  logic         wrap_tc;
  logic         at_tc;
  logic         roll_all;

  assign at_tc = (count == tc_val);

  // Next-state and datapath command decode; clr is applied in the registers.
  always_comb begin
    state_next = state;
    inc        = 1'b0;
    ld_all     = 1'b0;
    ld_data    = {W{1'b0}};
    wrap_tc    = 1'b0;
    if (load) begin
      ld_all     = 1'b1;
      ld_data    = load_val;
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          // entering RUN leaves count untouched; counting starts next edge
          if (start) begin
            state_next = ST_RUN;
          end else begin
            state_next = state;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_next = ST_HOLD;
          end else if (at_tc) begin
            if (mode) begin
              state_next = ST_DONE;
            end else begin
              ld_all  = 1'b1;
              wrap_tc = 1'b1;
            end
          end else begin
            inc = 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            ld_all     = 1'b1;
            state_next = ST_RUN;
          end else begin
            state_next = ST_DONE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Digit cascade: each digit's enable is the synchronous carry-out of the one below.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic en_d;
    logic co_d;
    if (i == 0) begin : g_first
      assign en_d = inc;
    end else begin : g_next
      assign en_d = g_digit[i-1].co_d;
    end
    decade_digit u_digit (
      .clk (clk),
      .clr (clr),
      .en  (en_d),
      .ld  (ld_all),
      .d   (ld_data[4*i +: 4]),
      .q   (count[4*i +: 4]),
      .co  (co_d)
    );
  end

  // Carry out of the top digit marks the natural all-9s -> all-0s rollover.
  assign roll_all = g_digit[DIGITS-1].co_d;

  // FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == ST_RUN);
      done    <= (state_next == ST_DONE);
      wrap    <= wrap_tc | roll_all;
    end
  end

endmodule

// File: tb/tb_decade_counter_ctrl.sv
// tb_decade_counter_ctrl: self-checking bench for decade_counter_ctrl (DIGITS = 4).
// A decimal-integer reference model predicts {count, running, done, wrap} for every
// clock; predictions go into exp_q as stimulus is applied, DUT samples into obs_q
// one unit after the edge, and each scenario task drains and compares both queues.
module tb_decade_counter_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic         stop;
  logic         load;
  logic         mode;
  logic [W-1:0] load_val;
  logic [W-1:0] tc_val;
  logic [W-1:0] count;
  logic         running;
  logic         done;
  logic         wrap;

  int tests = 0;
  int fails = 0;

  logic [W+2:0] exp_q[$];
  logic [W+2:0] obs_q[$];

  // reference model state: 0 idle, 1 run, 2 hold, 3 done
  int m_cnt = 0;
  int m_st  = 0;
  bit m_wrap = 1'b0;

  always #5 clk = ~clk;

  decade_counter_ctrl #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .tc_val   (tc_val),
    .mode     (mode),
    .count    (count),
    .running  (running),
    .done     (done),
    .wrap     (wrap)
  );

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int bcd2int_sane(input logic [W-1:0] b);
    int v;
    int p;
    logic [3:0] dg;
    v = 0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      dg = b[4*k +: 4];
      if (dg <= 4'd9) v = v + int'(dg) * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic model_step();
    m_wrap = 1'b0;
    if (clr) begin
      m_cnt = 0;
      m_st  = 0;
    end else if (load) begin
      m_cnt = bcd2int_sane(load_val);
      m_st  = 0;
    end else begin
      case (m_st)
        0, 2: if (start) m_st = 1;
        1: begin
          if (stop) m_st = 2;
          else if (int2bcd(m_cnt) == tc_val) begin
            if (mode) m_st = 3;
            else begin
              m_cnt  = 0;
              m_wrap = 1'b1;
            end
          end else begin
            m_cnt = (m_cnt + 1) % 10000;
            if (m_cnt == 0) m_wrap = 1'b1;
          end
        end
        default: if (start) begin
          m_cnt = 0;
          m_st  = 1;
        end
      endcase
    end
  endtask

  task automatic cycle(input logic c, input logic ld, input logic [W-1:0] lv,
                       input logic st, input logic sp, input logic [W-1:0] tc,
                       input logic md);
    clr = c; load = ld; load_val = lv; start = st; stop = sp; tc_val = tc; mode = md;
    model_step();
    exp_q.push_back({int2bcd(m_cnt), m_st == 1, m_st == 3, m_wrap});
    @(posedge clk);
    #1;
    obs_q.push_back({count, running, done, wrap});
  endtask

  task automatic test_reset();
    logic [W+2:0] e, o;
    cycle(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0);
    tests++;
    if ({count, running, done, wrap} !== {16'h0000, 3'b000}) begin
      fails++;
      $display("FAIL reset_state: got %h/%b%b%b want 0000/000", count, running, done, wrap);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL reset_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_load_priority();
    logic [W+2:0] e, o;
    cycle(1'b0, 1'b1, 16'h9F3C, 1'b1, 1'b0, 16'h0100, 1'b0);
    tests++;
    if ({count, running} !== {16'h9030, 1'b0}) begin
      fails++;
      $display("FAIL load_priority: got %h run=%b want 9030 run=0", count, running);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL load_priority_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_wrap_tc();
    logic [W+2:0] e, o;
    logic [W-1:0] c[6];
    logic         w[6];
    cycle(1'b0, 1'b1, 16'h0097, 1'b0, 1'b0, 16'h0100, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0);
      c[k] = count;
      w[k] = wrap;
    end
    tests++;
    if ({c[1], c[2], c[3], c[4], w[3], w[4], w[5]} !== {16'h0098, 16'h0099, 16'h0100, 16'h0000, 3'b010}) begin
      fails++;
      $display("FAIL wrap_tc: got %h %h %h %h wrap %b%b%b want 0098 0099 0100 0000 wrap 010",
               c[1], c[2], c[3], c[4], w[3], w[4], w[5]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL wrap_tc_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_oneshot();
    logic [W+2:0] e, o;
    cycle(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0005, 1'b1);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 1'b1);
    for (int k = 0; k < 7; k++) cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0005, 1'b1);
    tests++;
    if ({count, running, done, wrap} !== {16'h0005, 3'b010}) begin
      fails++;
      $display("FAIL oneshot_done: got %h/%b%b%b want 0005/010", count, running, done, wrap);
    end
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 1'b1);
    tests++;
    if ({count, running, done} !== {16'h0000, 2'b10}) begin
      fails++;
      $display("FAIL oneshot_restart: got %h/%b%b want 0000/10", count, running, done);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL oneshot_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_start_stop();
    logic [W+2:0] e, o;
    cycle(1'b0, 1'b1, 16'h0011, 1'b0, 1'b0, 16'h0500, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0500, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0500, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0500, 1'b0);
    tests++;
    if ({count, running} !== {16'h0012, 1'b0}) begin
      fails++;
      $display("FAIL stop_hold: got %h run=%b want 0012 run=0", count, running);
    end
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0500, 1'b0);
    tests++;
    if ({count, running} !== {16'h0012, 1'b1}) begin
      fails++;
      $display("FAIL resume_entry: got %h run=%b want 0012 run=1", count, running);
    end
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0500, 1'b0);
    tests++;
    if (count !== 16'h0013) begin
      fails++;
      $display("FAIL resume_inc: got %h want 0013", count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL start_stop_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_clr_mid_run();
    logic [W+2:0] e, o;
    cycle(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, 16'h0500, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0500, 1'b0);
    cycle(1'b1, 1'b1, 16'h0077, 1'b1, 1'b0, 16'h0500, 1'b0);
    tests++;
    if ({count, running, done, wrap} !== {16'h0000, 3'b000}) begin
      fails++;
      $display("FAIL clr_mid_run: got %h/%b%b%b want 0000/000", count, running, done, wrap);
    end
    cycle(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0500, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0500, 1'b0);
    tests++;
    if ({count, running} !== {16'h0000, 1'b1}) begin
      fails++;
      $display("FAIL clr_release: got %h run=%b want 0000 run=1", count, running);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL clr_mid_run_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_invalid_tc();
    logic [W+2:0] e, o;
    logic [W-1:0] c[4];
    logic         w[4];
    cycle(1'b0, 1'b1, 16'h9998, 1'b0, 1'b0, 16'h00A0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h00A0, 1'b0);
      c[k] = count;
      w[k] = wrap;
    end
    tests++;
    if ({c[1], c[2], c[3], w[1], w[2], w[3]} !== {16'h9999, 16'h0000, 16'h0001, 3'b010}) begin
      fails++;
      $display("FAIL invalid_tc: got %h %h %h wrap %b%b%b want 9999 0000 0001 wrap 010",
               c[1], c[2], c[3], w[1], w[2], w[3]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL invalid_tc_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_random();
    logic [W+2:0] e, o;
    logic [W-1:0] tc;
    logic         md;
    tc = int2bcd(25);
    md = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 29) == 0) tc = int2bcd(int'($urandom_range(0, 60)));
      if ($urandom_range(0, 39) == 0) md = ~md;
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0, 16'($urandom),
            $urandom_range(0, 1) == 0, $urandom_range(0, 9) == 0, tc, md);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL random_sb: got %h want %h", o, e); end
    end
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; mode = 1'b0;
    load_val = 16'h0000; tc_val = 16'h0000;
    test_reset();
    test_load_priority();
    test_wrap_tc();
    test_oneshot();
    test_start_stop();
    test_clr_mid_run();
    test_invalid_tc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
